// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage core: load-use stalls and control-transfer
// bubbles driven by one RUN/CTRL_WAIT FSM plus saturating stall/flush counters.
module hazard_sequencer #(
  parameter int BRANCH_PENALTY = 3,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_valid,
  input  logic [5:0]       ex_opcode,
  input  logic [4:0]       ex_rt,
  input  logic             branch_resolve,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [2:0] PENALTY = 3'(BRANCH_PENALTY);

  typedef enum logic {RUN, CTRL_WAIT} state_t;

  state_t     state;
  logic [2:0] penalty;
  logic       lu;
  logic       br;
  logic       jp;

  assign lu = ex_valid && (ex_opcode == OP_LW) && (ex_rt != 5'd0) && id_valid &&
              ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign br = id_valid && ((id_opcode == OP_BEQ) || (id_opcode == OP_BNE));
  assign jp = id_valid && (id_opcode == OP_J);

  // Load-use must stall in the same cycle it is seen, so RUN outputs follow the
  // decoded terms; CTRL_WAIT outputs depend on state alone.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    busy       = 1'b0;
    if (state == CTRL_WAIT) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      busy       = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      penalty <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (!lu && br) begin
            state   <= CTRL_WAIT;
            penalty <= PENALTY;
          end else if (!lu && jp) begin
            state   <= CTRL_WAIT;
            penalty <= 3'd1;
          end
        end
        CTRL_WAIT: begin
          if ((penalty == 3'd1) || branch_resolve) begin
            state   <= RUN;
            penalty <= 3'd0;
          end else begin
            penalty <= penalty - 3'd1;
          end
        end
        default: begin
          state   <= RUN;
          penalty <= 3'd0;
        end
      endcase
    end
  end

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_en && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if ((ifid_flush || idex_flush) && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
